// File: rtl/msk_hpc3_sched_pkg.sv
// Sizing helpers and FIFO entry type shared by the HPC3 AND scheduler files.
// DEFAULTSHARES sets the build-wide share count (2 unless defined externally).
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

package msk_sched_pkg;

  localparam int SCHED_D    = `DEFAULTSHARES;
  localparam int SCHED_NREQ = 4;

  function automatic int hpc3rnd(input int d);
    return d * (d - 1);
  endfunction

  function automatic int idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Result entry: product sharing plus the requester that asked for it.
  typedef struct packed {
    logic [SCHED_D-1:0]          data;
    logic [idw(SCHED_NREQ)-1:0]  id;
  } fifo_entry_t;

endpackage

// File: rtl/msk_hpc3_sched_if.sv
// Requester, randomness and result handshakes of the HPC3 AND scheduler.
// master = requester/PRNG/consumer side, slave = scheduler side.
interface msk_hpc3_sched_if
  import msk_sched_pkg::*;
#(
  parameter int d    = `DEFAULTSHARES,
  parameter int NREQ = 4
);
  localparam int HPC3RND = hpc3rnd(d);
  localparam int IDW     = idw(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*d-1:0] req_ina;
  logic [NREQ*d-1:0] req_inb;
  logic [HPC3RND-1:0] rnd_in;
  logic              rnd_valid;
  logic              rnd_ready;
  logic              out_valid;
  logic              out_ready;
  logic [d-1:0]      out_data;
  logic [IDW-1:0]    out_id;

  modport master (
    output req_valid, req_ina, req_inb, rnd_in, rnd_valid, out_ready,
    input  req_ready, rnd_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_ina, req_inb, rnd_in, rnd_valid, out_ready,
    output req_ready, rnd_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/msk_hpc3_sched_rr_arb.sv
// Round-robin arbiter: highest priority at index ptr, then ptr+1, ... wrapping.
// Produces a one-hot grant, its index and an any-request flag.
module msk_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'((v >= NREQ) ? v - NREQ : v);
  endfunction

  logic [IDW-1:0] cand [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand[gi] = wrap(int'(ptr) + gi);
  end

  // Walk from the lowest priority up so the closest candidate to ptr wins.
  always_comb begin
    any   = 1'b0;
    idx   = '0;
    grant = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        any = 1'b1;
        idx = cand[i];
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/msk_hpc3_sched.sv
// Shares one external HPC3 AND gadget among NREQ requesters with a 2-deep result FIFO.
// Define MSK_SCHED_IDLE_ZERO_EN to hold gadget inputs at zero in non-issue cycles.
module msk_hpc3_sched
  import msk_sched_pkg::*;
#(
  parameter int d    = `DEFAULTSHARES,
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  msk_hpc3_sched_if.slave       bus,
  output logic [d-1:0]          g_ina,
  output logic [d-1:0]          g_ina_prev,
  output logic [d-1:0]          g_inb,
  output logic [hpc3rnd(d)-1:0] g_rnd,
  input  logic [d-1:0]          g_out
);

  localparam int HPC3RND = hpc3rnd(d);
  localparam int IDW     = idw(NREQ);

  logic [IDW-1:0]  ptr_reg, ptr_next;
  logic            pending_reg;
  logic [IDW-1:0]  pending_id_reg;
  logic [d-1:0]    g_ina_prev_reg;
  fifo_entry_t     fifo_mem_reg [2];
  logic            wr_ptr_reg, rd_ptr_reg;
  logic [1:0]      fifo_count_reg;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic            issue, push, pop, room;
  logic [IDW-1:0]  sel_idx;
  logic [d-1:0]    ina_arr [NREQ];
  logic [d-1:0]    inb_arr [NREQ];

  msk_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign ina_arr[gi] = bus.req_ina[gi*d +: d];
    assign inb_arr[gi] = bus.req_inb[gi*d +: d];
  end

  // An issue now lands in the FIFO next cycle; allow it only if a slot is guaranteed.
  assign pop   = bus.out_valid & bus.out_ready;
  assign push  = pending_reg;
  assign room  = (int'(fifo_count_reg) + int'(pending_reg) - int'(pop)) <= 1;
  assign issue = !rst && arb_any && bus.rnd_valid && room;

  assign bus.req_ready = issue ? arb_grant : '0;
  assign bus.rnd_ready = issue;
  assign sel_idx       = issue ? arb_idx : ptr_reg;

`ifdef MSK_SCHED_IDLE_ZERO_EN
  assign g_ina = issue ? ina_arr[sel_idx] : '0;
  assign g_inb = issue ? inb_arr[sel_idx] : '0;
  assign g_rnd = issue ? bus.rnd_in : {HPC3RND{1'b0}};
`else
  assign g_ina = ina_arr[sel_idx];
  assign g_inb = inb_arr[sel_idx];
  assign g_rnd = bus.rnd_in;
`endif

  assign g_ina_prev = g_ina_prev_reg;

  always_comb begin
    ptr_next = ptr_reg;
    if (issue) ptr_next = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
  end

  assign bus.out_valid = (fifo_count_reg != 2'd0);
  assign bus.out_data  = fifo_mem_reg[rd_ptr_reg].data;
  assign bus.out_id    = fifo_mem_reg[rd_ptr_reg].id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg         <= '0;
      pending_reg     <= 1'b0;
      pending_id_reg  <= '0;
      g_ina_prev_reg  <= '0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      fifo_count_reg  <= 2'd0;
      fifo_mem_reg[0] <= '0;
      fifo_mem_reg[1] <= '0;
    end else begin
      ptr_reg        <= ptr_next;
      pending_reg    <= issue;
      pending_id_reg <= arb_idx;
      g_ina_prev_reg <= g_ina;
      if (push) begin
        fifo_mem_reg[wr_ptr_reg] <= '{data: g_out, id: pending_id_reg};
        wr_ptr_reg               <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 2'd1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 2'd1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_count_reg == 2'd2));

endmodule

// File: tb/tb_msk_hpc3_sched.sv
// Bench for msk_hpc3_sched (d=2, NREQ=4): directed phases then random traffic,
// checked against a queue-based model of grants, issue gating and result order.
module tb_msk_hpc3_sched;

  localparam int D    = 2;
  localparam int NREQ = 4;
  localparam int HR   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [D-1:0]  g_ina, g_ina_prev, g_inb;
  logic [D-1:0]  g_out;
  logic [HR-1:0] g_rnd;

  msk_hpc3_sched_if #(.d(D), .NREQ(NREQ)) bus ();

  msk_hpc3_sched #(.d(D), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .g_ina      (g_ina),
    .g_ina_prev (g_ina_prev),
    .g_inb      (g_inb),
    .g_rnd      (g_rnd),
    .g_out      (g_out)
  );

  always #5 clk = ~clk;

  // Two-share masked AND with one register stage, standing in for the external gadget.
  logic mask_bit;
  assign mask_bit = g_rnd[0] ^ g_rnd[1];
  always_ff @(posedge clk) begin
    g_out[0] <= (g_ina[0] & g_inb[0]) ^ (g_ina[0] & g_inb[1]) ^ mask_bit;
    g_out[1] <= (g_ina[1] & g_inb[1]) ^ (g_ina[1] & g_inb[0]) ^ mask_bit;
  end

  typedef struct {
    int id;
    bit prod;
    int cyc;
  } res_t;

  res_t         q[$];
  int           mptr = 0;
  int           cyc = 0;
  int           n_pass = 0;
  int           n_fail = 0;
  int           n_checks = 0;
  logic [D-1:0] exp_prev = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one cycle of stimulus, check at the falling edge, then advance the model.
  task automatic step(input logic [3:0] rv, input logic rndv, input logic ordy,
                      input logic [7:0] ina, input logic [7:0] inb, input logic [1:0] rnd);
    bit           ov, popm, iss;
    int           g, sel;
    logic [3:0]   expg;
    logic [D-1:0] e_ina, e_inb;
    logic [HR-1:0] e_rnd;
    bus.req_valid = rv;
    bus.rnd_valid = rndv;
    bus.out_ready = ordy;
    bus.req_ina   = ina;
    bus.req_inb   = inb;
    bus.rnd_in    = rnd;
    @(negedge clk);
    ov = (q.size() > 0) && (q[0].cyc <= cyc - 2);
    chk("out_valid", 32'(bus.out_valid), 32'(ov));
    if (ov) begin
      chk("out_id", 32'(bus.out_id), 32'(q[0].id));
      chk("out_xor", 32'(^bus.out_data), 32'(q[0].prod));
    end
    popm = ov && ordy;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (mptr + k) % NREQ;
      if (g < 0 && rv[c]) g = c;
    end
    iss  = (g >= 0) && rndv && ((q.size() - int'(popm)) <= 1);
    expg = iss ? 4'(1 << g) : 4'd0;
    chk("req_ready", 32'(bus.req_ready), 32'(expg));
    chk("rnd_ready", 32'(bus.rnd_ready), 32'(iss));
    sel   = iss ? g : mptr;
    e_ina = ina[sel*2 +: 2];
    e_inb = inb[sel*2 +: 2];
    e_rnd = rnd;
`ifdef MSK_SCHED_IDLE_ZERO_EN
    if (!iss) begin
      e_ina = '0;
      e_inb = '0;
      e_rnd = '0;
    end
`endif
    chk("g_ina", 32'(g_ina), 32'(e_ina));
    chk("g_inb", 32'(g_inb), 32'(e_inb));
    chk("g_rnd", 32'(g_rnd), 32'(e_rnd));
    chk("g_ina_prev", 32'(g_ina_prev), 32'(exp_prev));
    $display("cyc=%0d rv=%b rndv=%b ordy=%b grant=%b out_valid=%b out_id=%0d", cyc, rv, rndv,
             ordy, bus.req_ready, bus.out_valid, bus.out_id);
    exp_prev = e_ina;
    if (popm) void'(q.pop_front());
    if (iss) begin
      q.push_back('{id: g, prod: (^ina[g*2 +: 2]) & (^inb[g*2 +: 2]), cyc: cyc});
      mptr = (g + 1) % NREQ;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rstep(input logic [3:0] rv, input logic rndv, input logic ordy);
    step(rv, rndv, ordy, 8'($urandom), 8'($urandom), 2'($urandom));
  endtask

  // Hold reset for ncyc cycles with requests pending; everything in flight is discarded.
  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    bus.req_valid = '1;
    bus.rnd_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_ina   = 8'($urandom);
    bus.req_inb   = 8'($urandom);
    bus.rnd_in    = 2'($urandom);
    q.delete();
    mptr     = 0;
    exp_prev = '0;
    repeat (ncyc) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_id", 32'(bus.out_id), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rnd_ready", 32'(bus.rnd_ready), 32'd0);
      chk("rst_g_ina_prev", 32'(g_ina_prev), 32'd0);
      $display("cyc=%0d reset out_valid=%b req_ready=%b", cyc, bus.out_valid, bus.req_ready);
      cyc++;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    do_reset(2);

    // Single request from requester 0: a=(1,0), b=(0,1) -> product 1.
    step(4'b0001, 1'b1, 1'b1, 8'b0000_0001, 8'b0000_0010, 2'b01);
    repeat (3) rstep(4'b0000, 1'b1, 1'b1);

    // All requesters active: grants rotate one per cycle.
    repeat (8) rstep(4'b1111, 1'b1, 1'b1);
    repeat (3) rstep(4'b0000, 1'b1, 1'b1);

    // Randomness withheld, then supplied.
    repeat (3) rstep(4'b0010, 1'b0, 1'b1);
    rstep(4'b0010, 1'b1, 1'b1);
    repeat (3) rstep(4'b0000, 1'b1, 1'b1);

    // Consumer stalled: two results buffer, then issue resumes on drain.
    repeat (6) rstep(4'b1111, 1'b1, 1'b0);
    repeat (8) rstep(4'b1111, 1'b1, 1'b1);

    // Idle stretch.
    repeat (10) rstep(4'b0000, 1'b1, 1'b1);

    // Reset the cycle after an issue; next grant goes to lowest active index.
    rstep(4'b0100, 1'b1, 1'b1);
    do_reset(1);
    rstep(4'b1010, 1'b1, 1'b1);
    repeat (3) rstep(4'b0000, 1'b1, 1'b1);

    // Random traffic.
    repeat (400) rstep(4'($urandom), ($urandom % 4) != 0, ($urandom % 3) != 0);
    repeat (5) rstep(4'b0000, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
